// File: rtl/tone_generator.sv
// tone_generator: preset-driven square-wave speaker drive with rest and glitch-free preset updates
module tone_generator #(
  parameter int CNT_W = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] max_preset_in,
  input  logic [PRE_W-1:0] preset_8_in,
  output logic             spk_out,
  output logic             hp_done,
  output logic             resting
);
  typedef enum logic [1:0] {IDLE, RUN, REST} state_e;
  state_e           state_q, state_d;
  logic             spk_q, spk_d, hp_q, hp_d, rest_q, rest_d;
  logic [CNT_W-1:0] tone_q, tone_d, max_sh_q, max_sh_d;
  logic [PRE_W-1:0] pre_q, pre_d, pre_sh_q, pre_sh_d;
  logic             max_rest, tick, wrap, in_run, load;
  assign max_rest = &max_preset_in;
  assign tick     = pre_q == '0;
  assign wrap     = &tone_q;
  assign in_run   = state_q == RUN;
  assign load     = en && (!in_run || (tick && wrap));
  assign spk_out  = spk_q;
  assign hp_done  = hp_q;
  assign resting  = rest_q;
  // Next state: en=0 forces idle; entry, rest re-sampling and half-period boundaries all reload from the inputs
  always_comb begin
    state_d  = state_q;
    spk_d    = spk_q;
    hp_d     = 1'b0;
    rest_d   = rest_q;
    tone_d   = tone_q;
    pre_d    = pre_q;
    max_sh_d = max_sh_q;
    pre_sh_d = pre_sh_q;
    if (!en) begin
      state_d = IDLE;
      spk_d   = 1'b0;
      rest_d  = 1'b0;
    end else if (load) begin
      max_sh_d = max_preset_in;
      pre_sh_d = preset_8_in;
      tone_d   = max_preset_in;
      pre_d    = preset_8_in;
      state_d  = max_rest ? REST : RUN;
      rest_d   = max_rest;
      spk_d    = (in_run && !max_rest) ? ~spk_q : 1'b0;
      hp_d     = in_run && !max_rest;
    end else if (tick) begin
      tone_d = tone_q + 1'b1;
      pre_d  = pre_sh_q;
    end else begin
      pre_d = pre_q - 1'b1;
    end
  end
  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      spk_q    <= 1'b0;
      hp_q     <= 1'b0;
      rest_q   <= 1'b0;
      tone_q   <= '1;
      pre_q    <= '0;
      max_sh_q <= '1;
      pre_sh_q <= '0;
    end else begin
      state_q  <= state_d;
      spk_q    <= spk_d;
      hp_q     <= hp_d;
      rest_q   <= rest_d;
      tone_q   <= tone_d;
      pre_q    <= pre_d;
      max_sh_q <= max_sh_d;
      pre_sh_q <= pre_sh_d;
    end
  end
endmodule

// File: tb/tb_tone_generator.sv
// tb_tone_generator: randomized and directed checks of tone_generator against a half-period duration model
module tb_tone_generator;
  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [7:0] mx = 8'hFF;
  logic [3:0] pr = 4'h0;
  logic       spk_out, hp_done, resting;
  int         n_chk = 0, n_pass = 0;
  int         m_mode = 0, m_rem = 0;
  bit         m_spk = 0, m_hp = 0, m_rest = 0;

  always #5 clk = ~clk;

  tone_generator #(.CNT_W(8), .PRE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .max_preset_in(mx), .preset_8_in(pr),
    .spk_out(spk_out), .hp_done(hp_done), .resting(resting)
  );

  function automatic int half(input logic [7:0] m, input logic [3:0] p);
    return (256 - int'(m)) * (int'(p) + 1);
  endfunction

  // Model: mode 0 idle, 1 tone (m_rem cycles left in half period), 2 rest
  task automatic cyc();
    if (!rst_n || !en) begin
      m_mode = 0; m_spk = 0; m_hp = 0; m_rest = 0;
    end else if (m_mode == 1) begin
      m_hp = 0;
      m_rem--;
      if (m_rem == 0) begin
        if (mx == 8'hFF) begin
          m_mode = 2; m_spk = 0; m_rest = 1;
        end else begin
          m_spk = !m_spk; m_hp = 1; m_rem = half(mx, pr);
        end
      end
    end else begin
      m_hp = 0; m_spk = 0;
      if (mx == 8'hFF) begin
        m_mode = 2; m_rest = 1;
      end else begin
        m_mode = 1; m_rest = 0; m_rem = half(mx, pr);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; en = 1; mx = 8'hFC; pr = 4'h1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      n_chk++;
      if ({spk_out, hp_done, resting} !== 3'b000) $display("FAIL reset cyc %0d: outs=%b%b%b required 000", k, spk_out, hp_done, resting);
      else n_pass++;
    end
    rst_n = 1; en = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_chk++;
      if ({spk_out, hp_done, resting} !== 3'b000) $display("FAIL idle_after_reset cyc %0d: outs=%b%b%b required 000", k, spk_out, hp_done, resting);
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    int first = -1, pulses = 0;
    mx = 8'hFC; pr = 4'h1; en = 1;
    cyc();
    for (int k = 1; k <= 40; k++) begin
      cyc();
      n_chk++;
      if ({spk_out, hp_done, resting} !== {m_spk, m_hp, m_rest}) $display("FAIL basic cyc %0d: outs=%b%b%b required %b%b%b", k, spk_out, hp_done, resting, m_spk, m_hp, m_rest);
      else n_pass++;
      if (spk_out === 1'b1 && first < 0) first = k;
      if (hp_done === 1'b1) pulses++;
    end
    n_chk++;
    if (first !== 8) $display("FAIL basic_first_rise: got %0d required 8", first);
    else n_pass++;
    n_chk++;
    if (pulses !== 5) $display("FAIL basic_hp_count: got %0d required 5", pulses);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int t[$];
    logic prev;
    en = 0;
    cyc();
    mx = 8'hF0; pr = 4'h0; en = 1;
    cyc();
    prev = spk_out;
    for (int k = 1; k <= 24; k++) begin
      if (k == 6) mx = 8'hFE;
      cyc();
      n_chk++;
      if ({spk_out, hp_done, resting} !== {m_spk, m_hp, m_rest}) $display("FAIL glitch cyc %0d: outs=%b%b%b required %b%b%b", k, spk_out, hp_done, resting, m_spk, m_hp, m_rest);
      else n_pass++;
      if (spk_out !== prev) t.push_back(k);
      prev = spk_out;
    end
    n_chk++;
    if (t.size() < 2 || t[0] != 16 || t[1] != 18) $display("FAIL glitch_toggles: got %p required first two at 16,18", t);
    else n_pass++;
  endtask

  task automatic test_rest();
    mx = 8'hFF;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      n_chk++;
      if ({spk_out, hp_done, resting} !== {m_spk, m_hp, m_rest}) $display("FAIL rest cyc %0d: outs=%b%b%b required %b%b%b", k, spk_out, hp_done, resting, m_spk, m_hp, m_rest);
      else n_pass++;
      if (k == 2) begin
        n_chk++;
        if ({spk_out, hp_done, resting} !== 3'b001) $display("FAIL rest_entry: outs=%b%b%b required 001", spk_out, hp_done, resting);
        else n_pass++;
      end
    end
    mx = 8'hFE;
    cyc();
    n_chk++;
    if ({spk_out, hp_done, resting} !== 3'b000) $display("FAIL rest_exit: outs=%b%b%b required 000", spk_out, hp_done, resting);
    else n_pass++;
    cyc();
    cyc();
    n_chk++;
    if ({spk_out, hp_done, resting} !== 3'b110) $display("FAIL rest_first_toggle: outs=%b%b%b required 110", spk_out, hp_done, resting);
    else n_pass++;
  endtask

  task automatic test_extremes();
    int first = -1;
    en = 0;
    cyc();
    mx = 8'h00; pr = 4'hF; en = 1;
    cyc();
    for (int k = 1; k <= 4100; k++) begin
      cyc();
      n_chk++;
      if ({spk_out, hp_done, resting} !== {m_spk, m_hp, m_rest}) $display("FAIL slow cyc %0d: outs=%b%b%b required %b%b%b", k, spk_out, hp_done, resting, m_spk, m_hp, m_rest);
      else n_pass++;
      if (spk_out === 1'b1 && first < 0) first = k;
    end
    n_chk++;
    if (first !== 4096) $display("FAIL slow_first_rise: got %0d required 4096", first);
    else n_pass++;
    en = 0;
    cyc();
    mx = 8'hFE; pr = 4'h0; en = 1;
    cyc();
    for (int k = 1; k <= 8; k++) begin
      cyc();
      n_chk++;
      if (spk_out !== ((k % 4 == 2 || k % 4 == 3) ? 1'b1 : 1'b0) || hp_done !== (k % 2 == 0))
        $display("FAIL fast cyc %0d: spk=%b hp=%b required spk=%b hp=%b", k, spk_out, hp_done, (k % 4 == 2 || k % 4 == 3), (k % 2 == 0));
      else n_pass++;
    end
    m_spk = 0;
    m_hp = 0;
    m_rem = 2;
  endtask

  task automatic test_en_reset();
    int first = -1;
    bit found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cyc();
      if (spk_out === 1'b1) found = 1;
    end
    n_chk++;
    if (!found) $display("FAIL en_wait_high: spk_out never rose within 20 cycles, got %b required 1", spk_out);
    else n_pass++;
    en = 0;
    cyc();
    n_chk++;
    if ({spk_out, hp_done, resting} !== 3'b000) $display("FAIL en_drop: outs=%b%b%b required 000", spk_out, hp_done, resting);
    else n_pass++;
    mx = 8'hF0; pr = 4'h0; en = 1;
    for (int k = 0; k < 6; k++) cyc();
    rst_n = 0;
    cyc();
    n_chk++;
    if ({spk_out, hp_done, resting} !== 3'b000) $display("FAIL mid_reset: outs=%b%b%b required 000", spk_out, hp_done, resting);
    else n_pass++;
    rst_n = 1;
    cyc();
    for (int k = 1; k <= 20; k++) begin
      cyc();
      n_chk++;
      if ({spk_out, hp_done, resting} !== {m_spk, m_hp, m_rest}) $display("FAIL post_reset cyc %0d: outs=%b%b%b required %b%b%b", k, spk_out, hp_done, resting, m_spk, m_hp, m_rest);
      else n_pass++;
      if (spk_out === 1'b1 && first < 0) first = k;
    end
    n_chk++;
    if (first !== 16) $display("FAIL post_reset_first_rise: got %0d required 16", first);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 99) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) begin
        mx = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'(8'hE0 + $urandom_range(0, 30));
        pr = 4'($urandom_range(0, 3));
      end
      cyc();
      n_chk++;
      if ({spk_out, hp_done, resting} !== {m_spk, m_hp, m_rest}) $display("FAIL random cyc %0d: outs=%b%b%b required %b%b%b", k, spk_out, hp_done, resting, m_spk, m_hp, m_rest);
      else n_pass++;
    end
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_rest();
    test_extremes();
    test_en_reset();
    en = 1;
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
